systolic_mac_cell: RTL
======================

Name: systolic_mac_cell

Overview:
- Generalised processing element for the bicubic systolic array.
- Computes sum = pre_sum + channel x coef. The coefficient is a runtime-loadable signed register (double-buffered), not a fixed per-position multiplier, so one cell type serves every kernel tap.
- Has an optional multiplier pipeline stage, valid/channel forwarding to the neighbour cell, saturation, and a sticky overflow flag.
- Cells chain horizontally: channel_out feeds the next cell's channel, and sum feeds the next cell's pre_sum.

Parameters:
- DATA_W, 8: unsigned pixel channel width.
- FRACTION_BITS, 16: fraction bits F of sum and coefficient.
- INT_BITS, 10: integer bits of sum, including sign. SUM_W = INT_BITS + FRACTION_BITS.
- COEF_W, 18: signed coefficient width, format Q(COEF_W-F).F.
- COEF_INIT, 0: reset value of the shadow and active coefficients.
- PIPE_MULT, 1: 0 = combinational product; 1 = one register stage after the multiplier.
- SATURATE, 1: 1 = clamp sum on overflow; 0 = two's-complement wrap.

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset
- coef_wr  in  1  write coef_data into the shadow coefficient
- coef_data  in  COEF_W  signed coefficient
- coef_swap  in  1  copy shadow into active
- in_valid  in  1  channel/pre_sum qualifier
- channel  in  DATA_W  unsigned pixel
- pre_sum  in  SUM_W  signed partial sum from the upstream cell, aligned with channel
- out_valid  out  1  sum/channel_out qualifier
- channel_out  out  DATA_W  channel delayed by L, for the downstream cell
- sum  out  SUM_W  signed result
- ovf  out  1  sticky overflow flag
- ovf_clr  in  1  clears ovf

Behaviour:
- Reset:
  - Reset is aresetn, asynchronous, active-low; clock is aclk.
  - While aresetn=0: sum, channel_out, out_valid and ovf are 0; shadow and active coefficients are COEF_INIT; the pipeline valid bit is cleared.
  - Reset mid-operation discards in-flight samples. The first output after release comes only from a new in_valid.
- Latency: L = 1 + PIPE_MULT cycles from in_valid to out_valid. out_valid is a delayed copy of in_valid, one bit per stage. No backpressure.
- Gating: when a stage's valid is 0, that stage's data registers hold their value. sum and channel_out hold their last values while out_valid=0.
- pre_sum alignment: with PIPE_MULT=1, pre_sum is registered alongside the product, so callers present pre_sum in the same cycle as channel.
- Arithmetic:
  - prod = signed({1'b0, channel}) x signed(active_coef), width DATA_W+COEF_W+1, with F fraction bits.
  - Internal sum width ACC_W = max(SUM_W, DATA_W+COEF_W+1) + 1, with both operands sign-extended. No precision is lost before the final clamp.
- Overflow: overflow means the internal sum is outside [-2^(SUM_W-1), 2^(SUM_W-1)-1].
  - SATURATE=1: sum is clamped to the violated bound.
  - SATURATE=0: sum takes the low SUM_W bits.
  - Either mode: ovf is set on the cycle out_valid rises with an overflowing result.
- ovf and ovf_clr:
  - ovf is cleared by ovf_clr.
  - If ovf_clr and a new overflow occur in the same cycle, the set wins (ovf=1).
- Coefficients:
  - coef_wr loads the shadow register at the clock edge. It does not affect the active coefficient.
  - coef_swap loads active <= shadow at the clock edge. Samples whose in_valid is sampled at that same edge still use the old active coefficient; the first sample sampled at a later edge uses the new one.
  - coef_wr and coef_swap in the same cycle: the swap transfers the old shadow, and the shadow takes the new coef_data.
  - A swap affects a sample only when it enters the multiplier. In-flight products are never recomputed.
- Fully pipelined: one sample per cycle sustained. Back-to-back in_valid produces back-to-back out_valid with no bubbles.

Decomposition:
- Shared package bicubic_pkg holds:
  - the default FRACTION_BITS and INT_BITS;
  - the function computing SUM_W;
  - the coefficient fixed-point constants ONE = 2^F, HALF = 2^(F-1);
  - saturation bound constants derived from SUM_W.
- One natural sub-module, sat_round_add: it does the sign-extended add, clamp/wrap and overflow detect. It is reused by the later row accumulator.
- The valid/channel delay line stays inline.

Test Plan (F=16, COEF_W=18, SUM_W=26, PIPE_MULT=1):
- Basic MAC:
  - Stimulus: reset; coef_wr 0x08000 (0.5); coef_swap; in_valid with channel=200, pre_sum=0.
  - Response: out_valid exactly 2 cycles later; sum=6553600 (100.0); channel_out=200; ovf=0.
- Negative coefficient:
  - Stimulus: coef 245760 (-0.25); channel=100; pre_sum=1966080 (30.0).
  - Response: sum=327680 (5.0).
- Saturation:
  - Stimulus: coef 65536 (1.0); channel=255; pre_sum=0x1FFFFFF.
  - Response: sum=0x1FFFFFF, ovf=1 and held. Then ovf_clr in a cycle with no overflowing result: ovf=0 next cycle. Repeat with SATURATE=0: sum = low 26 bits of the true sum, ovf=1.
- Swap timing:
  - Stimulus: back-to-back stream of channel=10; shadow=2.0, active=1.0; coef_swap asserted at sample k.
  - Response: samples up to and including k give sum=10.0; sample k+1 onward give 20.0; no bubble in out_valid.
- Gating and hold:
  - Stimulus: in_valid pulses with 3-cycle gaps.
  - Response: out_valid pulses one cycle wide; sum and channel_out constant between pulses.
- Reset mid-stream:
  - Stimulus: assert aresetn=0 with 2 samples in flight.
  - Response: out_valid, sum, ovf immediately 0; coefficient = COEF_INIT; no out_valid after release until a new in_valid.

Source files
------------

// File: rtl/bicubic_pkg.sv
// Shared fixed-point definitions for the bicubic systolic array: default
// sum format, sum-width helper, coefficient constants and saturation bounds.
package bicubic_pkg;

  localparam int FRACTION_BITS_DEF = 16;
  localparam int INT_BITS_DEF      = 10;

  // Width of a partial sum: integer bits (sign included) plus fraction bits.
  function automatic int sum_width(input int int_bits, input int frac_bits);
    return int_bits + frac_bits;
  endfunction

  // Larger of two widths, used when sizing internal accumulators.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int SUM_W_DEF = sum_width(INT_BITS_DEF, FRACTION_BITS_DEF);

  // Coefficient values 1.0 and 0.5 in the default fraction format.
  localparam longint COEF_ONE  = longint'(1) << FRACTION_BITS_DEF;
  localparam longint COEF_HALF = longint'(1) << (FRACTION_BITS_DEF - 1);

  // Representable range of a default-width partial sum.
  localparam longint SUM_MAX = (longint'(1) << (SUM_W_DEF - 1)) - 1;
  localparam longint SUM_MIN = -(longint'(1) << (SUM_W_DEF - 1));

endpackage

// File: rtl/sat_round_add.sv
// Full-precision signed add of two operands followed by clamp or wrap into
// OUT_W bits, with an overflow indication. Shared with the row accumulator.
module sat_round_add
  import bicubic_pkg::*;
#(
  parameter int A_W      = 26,
  parameter int B_W      = 27,
  parameter int OUT_W    = 26,
  parameter int SATURATE = 1
) (
  input  logic signed [A_W-1:0]   a,
  input  logic signed [B_W-1:0]   b,
  output logic signed [OUT_W-1:0] y,
  output logic                    ovf
);

  // One guard bit above the widest operand keeps the add exact.
  localparam int ACC_W = max_int(max_int(A_W, B_W), OUT_W) + 1;

  logic signed [ACC_W-1:0] acc;
  logic [ACC_W-OUT_W:0]    top_bits;

  // Exact sum, range check on the bits above the output sign, then clamp/wrap.
  always_comb begin
    // NOTE: every output gets a value before any branch so no latch is inferred.
    acc      = {{(ACC_W-A_W){a[A_W-1]}}, a} + {{(ACC_W-B_W){b[B_W-1]}}, b};
    top_bits = acc[ACC_W-1:OUT_W-1];
    ovf      = ~((&top_bits) | (~|top_bits));
    y        = acc[OUT_W-1:0];
    if (ovf && (SATURATE != 0)) begin
      y = acc[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/systolic_mac_cell.sv
// Systolic processing element: sum = pre_sum + channel * coef, with a
// double-buffered runtime coefficient, optional multiplier pipeline stage,
// saturation/wrap, sticky overflow and valid/channel forwarding.
module systolic_mac_cell
  import bicubic_pkg::*;
#(
  parameter int                       DATA_W        = 8,
  parameter int                       FRACTION_BITS = FRACTION_BITS_DEF,
  parameter int                       INT_BITS      = INT_BITS_DEF,
  parameter int                       COEF_W        = 18,
  parameter logic signed [COEF_W-1:0] COEF_INIT     = '0,
  parameter int                       PIPE_MULT     = 1,
  parameter int                       SATURATE      = 1,
  localparam int                      SUM_W         = sum_width(INT_BITS, FRACTION_BITS)
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              coef_wr,
  input  logic [COEF_W-1:0] coef_data,
  input  logic              coef_swap,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] channel,
  input  logic [SUM_W-1:0]  pre_sum,
  output logic              out_valid,
  output logic [DATA_W-1:0] channel_out,
  output logic [SUM_W-1:0]  sum,
  output logic              ovf,
  input  logic              ovf_clr
);

  localparam int PROD_W = DATA_W + COEF_W + 1;

  logic signed [COEF_W-1:0] shadow_coef;
  logic signed [COEF_W-1:0] active_coef;
  logic signed [PROD_W-1:0] prod;

  // Stage feeding the adder (registered or straight through).
  logic                     s_valid;
  logic signed [PROD_W-1:0] s_prod;
  logic [SUM_W-1:0]         s_pre_sum;
  logic [DATA_W-1:0]        s_channel;

  logic signed [SUM_W-1:0]  add_sum;
  logic                     add_ovf;

  // Coefficient double buffer: writes land in shadow, swap publishes to active.
  always_ff @(posedge aclk or negedge aresetn) begin
    // NOTE: non-blocking assignments make a same-edge write+swap move the old shadow.
    if (!aresetn) begin
      shadow_coef <= COEF_INIT;
      active_coef <= COEF_INIT;
    end else begin
      if (coef_wr) begin
        shadow_coef <= coef_data;
      end
      if (coef_swap) begin
        active_coef <= shadow_coef;
      end
    end
  end

  // Unsigned pixel is zero-extended into a signed operand before multiplying.
  assign prod = $signed({1'b0, channel}) * active_coef;

  if (PIPE_MULT != 0) begin : g_pipe
    logic                     p_valid;
    logic signed [PROD_W-1:0] p_prod;
    logic [SUM_W-1:0]         p_pre_sum;
    logic [DATA_W-1:0]        p_channel;

    // Product stage: capture product with its aligned pre_sum and channel.
    always_ff @(posedge aclk or negedge aresetn) begin
      // NOTE: data registers are reset too so the post-reset hold value is defined.
      if (!aresetn) begin
        p_valid   <= 1'b0;
        p_prod    <= '0;
        p_pre_sum <= '0;
        p_channel <= '0;
      end else begin
        p_valid <= in_valid;
        if (in_valid) begin
          p_prod    <= prod;
          p_pre_sum <= pre_sum;
          p_channel <= channel;
        end
      end
    end

    assign s_valid   = p_valid;
    assign s_prod    = p_prod;
    assign s_pre_sum = p_pre_sum;
    assign s_channel = p_channel;
  end else begin : g_comb
    assign s_valid   = in_valid;
    assign s_prod    = prod;
    assign s_pre_sum = pre_sum;
    assign s_channel = channel;
  end

  sat_round_add #(
    .A_W      (SUM_W),
    .B_W      (PROD_W),
    .OUT_W    (SUM_W),
    .SATURATE (SATURATE)
  ) u_add (
    .a   ($signed(s_pre_sum)),
    .b   (s_prod),
    .y   (add_sum),
    .ovf (add_ovf)
  );

  // Output stage: register result and forwarded channel, hold while idle.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_valid   <= 1'b0;
      sum         <= '0;
      channel_out <= '0;
    end else begin
      out_valid <= s_valid;
      if (s_valid) begin
        sum         <= add_sum;
        channel_out <= s_channel;
      end
    end
  end

  // Sticky overflow: a new overflowing result wins over a clear request.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ovf <= 1'b0;
    end else if (s_valid && add_ovf) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

endmodule
